// File: rtl/hazard_scheduler.sv
// ID-stage issue controller: a shift-register scoreboard of in-flight destinations and flag
// writers drives the RAW/flag stall, and a taken EXE branch flushes the IF/ID instruction.
module hazard_scheduler #(
  parameter int DEPTH  = 2,
  parameter bit FWD_EN = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             id_cond_used,
  input  logic             id_wb_en,
  input  logic [3:0]       id_dest,
  input  logic             id_mem_r_en,
  input  logic             id_s,
  input  logic             exe_branch,
  output logic             hazard,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [3:0] dest;
    logic       ld;
    logic       s;
  } entry_t;

  entry_t             r_e [DEPTH];
  logic [CNT_W-1:0]   r_cnt;
  logic [DEPTH-1:0]   w_match;
  logic [DEPTH-1:0]   w_flag;
  logic               w_raw;
  logic               w_flg;
  logic               w_issue;
  entry_t             w_new;

  always_comb begin
    w_match = '0;
    w_flag  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_e[i].v &
                   ((id_use_src1 & (r_e[i].dest == id_src1)) |
                    (id_use_src2 & (r_e[i].dest == id_src2)));
      // Flag-only writers carry v=0, so the flag term looks at s alone.
      w_flag[i]  = r_e[i].s;
    end
  end

  always_comb begin
    w_raw = 1'b0;
    w_flg = 1'b0;
    if (FWD_EN) begin
      w_raw = r_e[0].ld & w_match[0];
      w_flg = 1'b0;
    end else begin
      w_raw = |w_match;
      w_flg = id_cond_used & (|w_flag);
    end
  end

  assign flush     = exe_branch;
  assign hazard    = id_valid & ~exe_branch & (w_raw | w_flg);
  assign w_issue   = id_valid & ~hazard & ~exe_branch;
  assign w_new     = {id_wb_en, id_dest, id_mem_r_en, id_s};
  assign stall_cnt = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_e[i] <= '0;
      end
    end else begin
      r_e[0] <= w_issue ? w_new : entry_t'(0);
      for (int i = 1; i < DEPTH; i++) begin
        r_e[i] <= r_e[i-1];
      end
    end
  end

  // Saturating stall counter: sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (hazard && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: three configurations share one stimulus stream and are
// compared against an issue-history reference model plus directed scenario checks.
module tb_hazard_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_src1, id_use_src2, id_cond_used, id_wb_en, id_mem_r_en, id_s;
  logic exe_branch;
  logic [3:0] id_src1, id_src2, id_dest;
  logic hazard0, hazard1, hazard2, flush0, flush1, flush2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  always #5 clk = ~clk;

  hazard_scheduler #(.DEPTH(2), .FWD_EN(1'b0), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_cond_used(id_cond_used),
    .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r_en(id_mem_r_en), .id_s(id_s),
    .exe_branch(exe_branch), .hazard(hazard0), .flush(flush0), .stall_cnt(cnt0));

  hazard_scheduler #(.DEPTH(2), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_cond_used(id_cond_used),
    .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r_en(id_mem_r_en), .id_s(id_s),
    .exe_branch(exe_branch), .hazard(hazard1), .flush(flush1), .stall_cnt(cnt1));

  hazard_scheduler #(.DEPTH(20), .FWD_EN(1'b0), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_cond_used(id_cond_used),
    .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r_en(id_mem_r_en), .id_s(id_s),
    .exe_branch(exe_branch), .hazard(hazard2), .flush(flush2), .stall_cnt(cnt2));

  typedef struct packed {
    logic       wb;
    logic [3:0] dest;
    logic       ld;
    logic       s;
  } ent_t;

  localparam int HMAX = 20;
  ent_t hist [3][HMAX];             // hist[k][a]: what instance k issued a+1 cycles ago
  int   cfg_depth [3] = '{2, 2, 20};
  int   cfg_fwd   [3] = '{0, 1, 0};
  int   cfg_max   [3] = '{65535, 65535, 15};
  int   m_cnt     [3];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // Reference rule: a reader waits while any producer of its operand (or, without forwarding,
  // any flag setter when it is conditional) issued within the last DEPTH cycles.
  function automatic bit model_hazard(int k);
    bit   raw;
    bit   flg;
    bit   hit;
    ent_t p;
    raw = 1'b0;
    flg = 1'b0;
    if (!id_valid || exe_branch) return 1'b0;
    for (int a = 0; a < cfg_depth[k]; a++) begin
      p   = hist[k][a];
      hit = p.wb && ((id_use_src1 && p.dest == id_src1) || (id_use_src2 && p.dest == id_src2));
      if (cfg_fwd[k] != 0) begin
        if (a == 0 && p.ld && hit) raw = 1'b1;
      end else begin
        if (hit) raw = 1'b1;
        if (id_cond_used && p.s) flg = 1'b1;
      end
    end
    return raw | flg;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      for (int a = 0; a < HMAX; a++) hist[k][a] = '0;
    end
  endtask

  task automatic tick();
    bit h;
    bit iss;
    for (int k = 0; k < 3; k++) begin
      h   = model_hazard(k);
      iss = id_valid && !h && !exe_branch;
      for (int a = HMAX - 1; a > 0; a--) hist[k][a] = hist[k][a-1];
      hist[k][0] = iss ? ent_t'({id_wb_en, id_dest, id_mem_r_en, id_s}) : ent_t'(0);
      if (h && m_cnt[k] < cfg_max[k]) m_cnt[k]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                       input logic u2, input logic cond, input logic wb, input logic [3:0] dst,
                       input logic ld, input logic s, input logic br);
    id_valid = v; id_src1 = s1; id_use_src1 = u1; id_src2 = s2; id_use_src2 = u2;
    id_cond_used = cond; id_wb_en = wb; id_dest = dst; id_mem_r_en = ld; id_s = s;
    exe_branch = br;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    model_clear();
    #3;
    total_cnt++; if (hazard0 !== 1'b0) $display("FAIL reset_hazard0: got %b want 0", hazard0); else pass_cnt++;
    total_cnt++; if (hazard2 !== 1'b0) $display("FAIL reset_hazard2: got %b want 0", hazard2); else pass_cnt++;
    total_cnt++; if (cnt0 !== 16'd0) $display("FAIL reset_cnt0: got %0d want 0", cnt0); else pass_cnt++;
    total_cnt++; if (cnt2 !== 4'd0) $display("FAIL reset_cnt2: got %0d want 0", cnt2); else pass_cnt++;
    total_cnt++; if (flush0 !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush0); else pass_cnt++;
    exe_branch = 1'b1;
    #1;
    total_cnt++; if (flush1 !== 1'b1) $display("FAIL flush_follows_branch: got %b want 1", flush1); else pass_cnt++;
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_raw_stall();
    apply_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);  // ADD R3
    #1;
    total_cnt++; if (hazard0 !== 1'b0) $display("FAIL raw_producer: got %b want 0", hazard0); else pass_cnt++;
    tick();
    drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);  // SUB reads R3
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++;
      if (hazard0 !== (c < 2 ? 1'b1 : 1'b0)) $display("FAIL raw_stall_c%0d: got %b want %b", c, hazard0, (c < 2));
      else pass_cnt++;
      tick();
    end
    idle();
    #1;
    total_cnt++; if (cnt0 !== 16'd2) $display("FAIL raw_stall_cnt: got %0d want 2", cnt0); else pass_cnt++;
  endtask

  task automatic test_fwd_load_use();
    apply_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);  // LDR R5
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);  // ADD uses R5
    #1;
    total_cnt++; if (hazard1 !== 1'b1) $display("FAIL fwd_load_use_c0: got %b want 1", hazard1); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (hazard1 !== 1'b0) $display("FAIL fwd_load_use_c1: got %b want 0", hazard1); else pass_cnt++;
    apply_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);  // MOV R5
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    #1;
    total_cnt++; if (hazard1 !== 1'b0) $display("FAIL fwd_alu_producer: got %b want 0", hazard1); else pass_cnt++;
  endtask

  task automatic test_flags();
    apply_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);  // CMP
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);  // BEQ
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++;
      if (hazard0 !== (c < 2 ? 1'b1 : 1'b0)) $display("FAIL flag_stall_c%0d: got %b want %b", c, hazard0, (c < 2));
      else pass_cnt++;
      tick();
    end
    apply_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);  // B (AL)
    #1;
    total_cnt++; if (hazard0 !== 1'b0) $display("FAIL flag_al_branch: got %b want 0", hazard0); else pass_cnt++;
  endtask

  task automatic test_branch_flush();
    apply_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1);  // RAW + branch
    #1;
    total_cnt++; if (flush0 !== 1'b1) $display("FAIL branch_flush: got %b want 1", flush0); else pass_cnt++;
    total_cnt++; if (hazard0 !== 1'b0) $display("FAIL branch_hazard: got %b want 0", hazard0); else pass_cnt++;
    tick();
    drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);  // reader of R7
    #1;
    total_cnt++; if (hazard0 !== 1'b0) $display("FAIL branch_dropped: got %b want 0", hazard0); else pass_cnt++;
    total_cnt++; if (cnt0 !== 16'd0) $display("FAIL branch_cnt: got %0d want 0", cnt0); else pass_cnt++;
  endtask

  task automatic test_saturation();
    apply_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      #1;
      total_cnt++; if (hazard2 !== 1'b1) $display("FAIL sat_hazard_c%0d: got %b want 1", j, hazard2); else pass_cnt++;
      total_cnt++;
      if (cnt2 !== 4'((j < 15) ? j : 15)) $display("FAIL sat_cnt_c%0d: got %0d want %0d", j, cnt2, (j < 15) ? j : 15);
      else pass_cnt++;
      tick();
    end
    #1;
    total_cnt++; if (hazard2 !== 1'b0) $display("FAIL sat_release: got %b want 0", hazard2); else pass_cnt++;
    total_cnt++; if (cnt2 !== 4'd15) $display("FAIL sat_hold: got %0d want 15", cnt2); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);  // reads R9, writes R1
    tick(); tick(); tick();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);  // writes R2
    tick();
    drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);  // reads R1
    #1;
    total_cnt++; if (hazard0 !== 1'b1) $display("FAIL pre_reset_hazard: got %b want 1", hazard0); else pass_cnt++;
    total_cnt++; if (cnt0 !== 16'd2) $display("FAIL pre_reset_cnt: got %0d want 2", cnt0); else pass_cnt++;
    #1;
    rst = 1'b1;
    model_clear();
    #1;
    total_cnt++; if (hazard0 !== 1'b0) $display("FAIL async_hazard: got %b want 0", hazard0); else pass_cnt++;
    total_cnt++; if (cnt0 !== 16'd0) $display("FAIL async_cnt: got %0d want 0", cnt0); else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++; if (hazard0 !== 1'b0) $display("FAIL post_reset_issue: got %b want 0", hazard0); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (cnt0 !== 16'd0) $display("FAIL post_reset_cnt: got %0d want 0", cnt0); else pass_cnt++;
  endtask

  task automatic test_random();
    logic        act_h [3];
    logic        act_f [3];
    int unsigned act_c [3];
    bit          exp_h;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, 4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)),
            1'($urandom), ($urandom % 3) == 0, 1'($urandom), 4'($urandom_range(0, 3)),
            ($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0);
      #1;
      act_h = '{hazard0, hazard1, hazard2};
      act_f = '{flush0, flush1, flush2};
      act_c = '{32'(cnt0), 32'(cnt1), 32'(cnt2)};
      for (int k = 0; k < 3; k++) begin
        exp_h = model_hazard(k);
        total_cnt++;
        if (act_h[k] !== exp_h) $display("FAIL rand_hazard[%0d] n=%0d: got %b want %b", k, n, act_h[k], exp_h);
        else pass_cnt++;
        total_cnt++;
        if (act_f[k] !== exe_branch) $display("FAIL rand_flush[%0d] n=%0d: got %b want %b", k, n, act_f[k], exe_branch);
        else pass_cnt++;
        total_cnt++;
        if (act_c[k] != m_cnt[k]) $display("FAIL rand_cnt[%0d] n=%0d: got %0d want %0d", k, n, act_c[k], m_cnt[k]);
        else pass_cnt++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_clear();
    test_reset();
    test_raw_stall();
    test_fwd_load_use();
    test_flags();
    test_branch_flush();
    test_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
